spi_ram_slave_ctrl: RTL and testbench

SPI slave front-end that terminates the frames issued by the SPI master and converts them into port-A accesses on the dual-port RAM. Each frame is 2*ADDR_SIZE bits, MSB first: an ADDR_SIZE-bit command byte followed by an ADDR_SIZE-bit payload. The block keeps independent write and read address pointers that auto-increment. Read data is returned on MISO during the payload half of the same frame.

---
 rtl/spi_ram_slave_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_spi_ram_slave_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_slave_ctrl.sv
// SPI slave front-end: terminates 2*ADDR_SIZE-bit frames (command + payload)
// and turns them into port-A RAM accesses with auto-incrementing pointers.
module spi_ram_slave_ctrl #(
    parameter bit CPOL      = 1'b0,
    parameter bit CPHA      = 1'b0,
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 spi_sclk,
    input  logic                 spi_cs_n,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic [ADDR_SIZE-1:0] ram_din,
    output logic                 ram_we,
    output logic                 ram_re,
    input  logic [ADDR_SIZE-1:0] ram_dout,
    output logic                 frame_done,
    output logic                 cmd_err
);

    localparam int CNT_W = $clog2(ADDR_SIZE);
    localparam logic [CNT_W-1:0]     CNT_LAST    = CNT_W'(ADDR_SIZE - 1);
    localparam logic [ADDR_SIZE-1:0] PTR_LAST    = ADDR_SIZE'(MEM_DEPTH - 1);
    localparam logic [ADDR_SIZE-1:0] CMD_WR_ADDR = ADDR_SIZE'(0);
    localparam logic [ADDR_SIZE-1:0] CMD_WR_DATA = ADDR_SIZE'(1);
    localparam logic [ADDR_SIZE-1:0] CMD_RD_ADDR = ADDR_SIZE'(2);
    localparam logic [ADDR_SIZE-1:0] CMD_RD_DATA = ADDR_SIZE'(3);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_FETCH, S_PAYLOAD, S_EXEC, S_WAIT_CS
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_SIZE-1:0]   rx_q, rx_d;
    logic [ADDR_SIZE-1:0]   cmd_q, cmd_d;
    logic [ADDR_SIZE-1:0]   tx_q, tx_d;
    logic [ADDR_SIZE-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_SIZE-1:0]   rd_ptr_q, rd_ptr_d;
    logic                   miso_q, miso_d;
    logic                   fetch_ph_q, fetch_ph_d;
    logic                   cmd_err_q, cmd_err_d;

    // Synchroniser chains; the third stage of sclk/cs_n is the edge-detect history.
    // Deliberately not reset so a reset with cs_n already low cannot fake a falling edge.
    logic [2:0] sclk_sync_q;
    logic [2:0] cs_sync_q;
    logic [1:0] mosi_sync_q;

    logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
    logic cs_hi, cs_fall, mosi_s, is_rd;
    logic [ADDR_SIZE-1:0] rx_shift;

    assign sclk_rise   = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall   = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
    assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign cs_hi       = cs_sync_q[1];
    assign cs_fall     = ~cs_sync_q[1] & cs_sync_q[2];
    assign mosi_s      = mosi_sync_q[1];
    assign rx_shift    = {rx_q[ADDR_SIZE-2:0], mosi_s};
    assign is_rd       = (cmd_q == CMD_RD_DATA);

    assign spi_miso = miso_q;
    assign cmd_err  = cmd_err_q;

    function automatic logic [ADDR_SIZE-1:0] ptr_inc(input logic [ADDR_SIZE-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Bring the asynchronous SPI pins into the clk domain
    always_ff @(posedge clk) begin
        sclk_sync_q <= {sclk_sync_q[1:0], spi_sclk};
        cs_sync_q   <= {cs_sync_q[1:0], spi_cs_n};
        mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
    end

    // Frame sequencer: next state, datapath updates and RAM strobes
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rx_d       = rx_q;
        cmd_d      = cmd_q;
        tx_d       = tx_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        miso_d     = 1'b0;
        fetch_ph_d = 1'b0;
        cmd_err_d  = 1'b0;
        ram_addr   = '0;
        ram_din    = '0;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cs_fall) begin
                    state_d = S_CMD;
                    cnt_d   = '0;
                    rx_d    = '0;
                end
            end
            S_CMD: begin
                if (cs_hi) begin
                    state_d = S_IDLE;
                end else if (sample_edge) begin
                    rx_d = rx_shift;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        cmd_d = rx_shift;
                        rx_d  = '0;
                        case (rx_shift)
                            CMD_RD_DATA:                          state_d = S_FETCH;
                            CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR: state_d = S_PAYLOAD;
                            default: begin
                                cmd_err_d = 1'b1;
                                state_d   = S_WAIT_CS;
                            end
                        endcase
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_FETCH: begin
                if (cs_hi) begin
                    state_d = S_IDLE;
                end else if (!fetch_ph_q) begin
                    ram_re     = 1'b1;
                    ram_addr   = rd_ptr_q;
                    fetch_ph_d = 1'b1;
                end else begin
                    state_d = S_PAYLOAD;
                    // CPHA=0: MSB must be on the wire before the first payload sample edge
                    if (!CPHA) begin
                        miso_d = ram_dout[ADDR_SIZE-1];
                        tx_d   = {ram_dout[ADDR_SIZE-2:0], 1'b0};
                    end else begin
                        tx_d   = ram_dout;
                    end
                end
            end
            S_PAYLOAD: begin
                miso_d = miso_q;
                if (cs_hi) begin
                    state_d = S_IDLE;
                    miso_d  = 1'b0;
                end else if (sample_edge) begin
                    rx_d = rx_shift;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        miso_d  = 1'b0;
                        state_d = S_EXEC;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (shift_edge && is_rd && (CPHA || cnt_q != '0)) begin
                    // With CPHA=0 the trailing edge of the last command bit lands here
                    // before any payload sample; it must not advance the tx register.
                    miso_d = tx_q[ADDR_SIZE-1];
                    tx_d   = {tx_q[ADDR_SIZE-2:0], 1'b0};
                end
            end
            S_EXEC: begin
                frame_done = 1'b1;
                state_d    = S_WAIT_CS;
                case (cmd_q)
                    CMD_WR_ADDR: wr_ptr_d = rx_q;
                    CMD_WR_DATA: begin
                        ram_we   = 1'b1;
                        ram_addr = wr_ptr_q;
                        ram_din  = rx_q;
                        wr_ptr_d = ptr_inc(wr_ptr_q);
                    end
                    CMD_RD_ADDR: rd_ptr_d = rx_q;
                    CMD_RD_DATA: rd_ptr_d = ptr_inc(rd_ptr_q);
                    default: ;
                endcase
            end
            S_WAIT_CS: begin
                if (cs_hi) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rx_q       <= '0;
            cmd_q      <= '0;
            tx_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            miso_q     <= 1'b0;
            fetch_ph_q <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rx_q       <= rx_d;
            cmd_q      <= cmd_d;
            tx_q       <= tx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            miso_q     <= miso_d;
            fetch_ph_q <= fetch_ph_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

endmodule

// File: tb/tb_spi_ram_slave_ctrl.sv
// Bench for spi_ram_slave_ctrl: two instances (mode 0/0 and 1/1) driven by a
// bit-level SPI master, checked against a frame-level reference model.
module tb_spi_ram_slave_ctrl;

    localparam int AW    = 8;
    localparam int DEPTH = 256;
    localparam int HALF  = 8;

    logic clk = 1'b0;
    logic rst;
    logic [1:0] sclk, cs_n, mosi, miso, we, re, done, err;
    logic [1:0][AW-1:0] addr, din, dout;

    logic [AW-1:0] ram     [2][DEPTH];
    logic [AW-1:0] mdl_mem [2][DEPTH];
    logic ram_init;

    int wp[2] = '{0, 0};
    int rp[2] = '{0, 0};
    int exp_re[2]   = '{0, 0};
    int exp_done[2] = '{0, 0};
    int exp_err[2]  = '{0, 0};
    int obs_re[2]   = '{0, 0};
    int obs_done[2] = '{0, 0};
    int obs_err[2]  = '{0, 0};
    int obs_excl[2] = '{0, 0};
    logic [16:0] wlog[$];
    logic [16:0] ewlog[$];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    spi_ram_slave_ctrl #(.CPOL(1'b0), .CPHA(1'b0), .MEM_DEPTH(DEPTH), .ADDR_SIZE(AW)) dut0 (
        .clk(clk), .rst(rst), .spi_sclk(sclk[0]), .spi_cs_n(cs_n[0]), .spi_mosi(mosi[0]),
        .spi_miso(miso[0]), .ram_addr(addr[0]), .ram_din(din[0]), .ram_we(we[0]),
        .ram_re(re[0]), .ram_dout(dout[0]), .frame_done(done[0]), .cmd_err(err[0]));

    spi_ram_slave_ctrl #(.CPOL(1'b1), .CPHA(1'b1), .MEM_DEPTH(DEPTH), .ADDR_SIZE(AW)) dut1 (
        .clk(clk), .rst(rst), .spi_sclk(sclk[1]), .spi_cs_n(cs_n[1]), .spi_mosi(mosi[1]),
        .spi_miso(miso[1]), .ram_addr(addr[1]), .ram_din(din[1]), .ram_we(we[1]),
        .ram_re(re[1]), .ram_dout(dout[1]), .frame_done(done[1]), .cmd_err(err[1]));

    function automatic logic [AW-1:0] pat(input int d, input int a);
        return AW'((a * 7 + 3 + d * 13) & 255);
    endfunction

    // Port-A RAM of the environment: read data one clk after ram_re
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ram_init) begin
                for (int a = 0; a < DEPTH; a++) ram[d][a] <= pat(d, a);
            end else begin
                if (we[d]) ram[d][addr[d]] <= din[d];
                if (re[d]) dout[d] <= ram[d][addr[d]];
            end
        end
    end

    // Strobe monitor: counts high cycles, logs writes
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (we[d]) wlog.push_back({1'(d), addr[d], din[d]});
            if (re[d]) obs_re[d]++;
            if (done[d]) obs_done[d]++;
            if (err[d]) obs_err[d]++;
            if (we[d] && re[d]) obs_excl[d]++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_outs(input int d);
        chk("rst_we",   32'(we[d]),   32'd0);
        chk("rst_re",   32'(re[d]),   32'd0);
        chk("rst_done", 32'(done[d]), 32'd0);
        chk("rst_err",  32'(err[d]),  32'd0);
        chk("rst_miso", 32'(miso[d]), 32'd0);
        chk("rst_addr", 32'(addr[d]), 32'd0);
        chk("rst_din",  32'(din[d]),  32'd0);
    endtask

    // Bit-level SPI master; captures MISO on the master sample edge of payload bits
    task automatic spi_frame(input int d, input logic [15:0] w, input int nbits,
                             input int rst_bit, output logic [7:0] rxb);
        logic cpol, cpha;
        cpol = (d == 1);
        cpha = (d == 1);
        rxb  = '0;
        @(negedge clk);
        cs_n[d] = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_bit) begin
                rst = 1'b1;
                @(negedge clk);
                chk_outs(d);
                rst = 1'b0;
            end
            if (!cpha) begin
                mosi[d] = w[15-i];
                repeat (HALF) @(negedge clk);
                sclk[d] = ~cpol;
                if (i >= 8) rxb = {rxb[6:0], miso[d]};
                repeat (HALF) @(negedge clk);
                sclk[d] = cpol;
            end else begin
                sclk[d] = ~cpol;
                mosi[d] = w[15-i];
                repeat (HALF) @(negedge clk);
                sclk[d] = cpol;
                if (i >= 8) rxb = {rxb[6:0], miso[d]};
                repeat (HALF) @(negedge clk);
            end
        end
        repeat (HALF) @(negedge clk);
        cs_n[d] = 1'b1;
        mosi[d] = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    // Frame-level reference: what one frame should do to pointers, RAM and strobes
    task automatic model_frame(input int d, input logic [15:0] w, input int nbits,
                               input int rst_bit, output logic [7:0] exp_rx, output bit use_rx);
        int cmd, pl;
        cmd    = int'(w[15:8]);
        pl     = int'(w[7:0]);
        exp_rx = '0;
        use_rx = 1'b0;
        if (rst_bit >= 0 && rst_bit < nbits) begin
            if (rst_bit >= 8 && cmd == 3) exp_re[d]++;
            if (rst_bit >= 8 && cmd > 3) exp_err[d]++;
            for (int k = 0; k < 2; k++) begin
                wp[k] = 0;
                rp[k] = 0;
            end
            return;
        end
        if (nbits < 16) begin
            if (nbits >= 8 && cmd == 3) exp_re[d]++;
            if (nbits >= 8 && cmd > 3) exp_err[d]++;
            return;
        end
        use_rx = 1'b1;
        case (cmd)
            0: begin wp[d] = pl; exp_done[d]++; end
            1: begin
                ewlog.push_back({1'(d), AW'(wp[d]), AW'(pl)});
                mdl_mem[d][wp[d]] = AW'(pl);
                wp[d] = (wp[d] + 1) % DEPTH;
                exp_done[d]++;
            end
            2: begin rp[d] = pl; exp_done[d]++; end
            3: begin
                exp_rx = mdl_mem[d][rp[d]];
                rp[d]  = (rp[d] + 1) % DEPTH;
                exp_re[d]++;
                exp_done[d]++;
            end
            default: exp_err[d]++;
        endcase
    endtask

    task automatic run(input int d, input logic [15:0] w, input int nbits, input int rst_bit);
        logic [7:0] rxb, exp_rx;
        bit use_rx;
        spi_frame(d, w, nbits, rst_bit, rxb);
        model_frame(d, w, nbits, rst_bit, exp_rx, use_rx);
        chk("frame_done_cnt", 32'(obs_done[d]), 32'(exp_done[d]));
        chk("ram_re_cnt",     32'(obs_re[d]),   32'(exp_re[d]));
        chk("cmd_err_cnt",    32'(obs_err[d]),  32'(exp_err[d]));
        chk("we_re_overlap",  32'(obs_excl[d]), 32'd0);
        chk("write_cnt",      32'(wlog.size()), 32'(ewlog.size()));
        while (wlog.size() > 0 && ewlog.size() > 0)
            chk("write_d_addr_data", 32'(wlog.pop_front()), 32'(ewlog.pop_front()));
        wlog.delete();
        ewlog.delete();
        if (use_rx) chk("miso_byte", 32'(rxb), 32'(exp_rx));
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] w;
        int d, nb, r;
        rst      = 1'b1;
        ram_init = 1'b1;
        sclk     = 2'b10;
        cs_n     = 2'b11;
        mosi     = 2'b00;
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < DEPTH; a++) mdl_mem[k][a] = pat(k, a);
        repeat (4) @(negedge clk);
        ram_init = 1'b0;
        rst      = 1'b0;
        @(negedge clk);
        chk_outs(0);
        chk_outs(1);

        // Write / read-back in both SPI modes
        for (int m = 0; m < 2; m++) begin
            run(m, 16'h0010, 16, -1);
            run(m, 16'h01AB, 16, -1);
            run(m, 16'h015C, 16, -1);
            run(m, 16'h0210, 16, -1);
            run(m, 16'h0300, 16, -1);
            run(m, 16'h0300, 16, -1);
        end

        // Write pointer wrap at the top of memory
        run(0, 16'h00FF, 16, -1);
        run(0, 16'h0111, 16, -1);
        run(0, 16'h0122, 16, -1);

        // Aborted write, then a full one to the same pointer
        run(0, 16'h01AB, 12, -1);
        run(0, 16'h01AB, 16, -1);

        // Unknown command leaves pointers alone
        run(0, 16'h0755, 16, -1);
        run(0, 16'h01C3, 16, -1);

        // Reset in the middle of a write payload
        run(0, 16'h01AB, 16, 12);
        run(0, 16'h0177, 16, -1);
        run(1, 16'h0188, 16, -1);

        // Randomised frames, including short ones and unknown commands
        for (int n = 0; n < 50; n++) begin
            d  = int'($urandom_range(0, 1));
            r  = int'($urandom_range(0, 9));
            nb = 16;
            if (r < 8)       w = {8'(r % 4), 8'($urandom_range(0, 255))};
            else if (r == 8) w = {8'($urandom_range(4, 255)), 8'($urandom_range(0, 255))};
            else begin
                w  = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 255))};
                nb = int'($urandom_range(1, 15));
            end
            run(d, w, nb, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
